// File: rtl/mem_pkg.sv
// Shared types and constants for the mem port arbiter and its masters.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH = 16;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_AUX = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    logic                  byt;
    logic [15:0]           wr_data;
  } mem_req_t;

  // A word access must be 16-bit aligned.
  function automatic logic misaligned(input mem_req_t r);
    return !r.byt && r.addr[0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with bounded ownership lock.
module rr_arb2
  import mem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  master_id_t    last;
  logic [CW-1:0] lock_cnt;
  logic          lock_flag;

  master_id_t win;
  logic       any;
  logic       hold;
  logic       win_lock;

  always_comb begin
    hold = lock_flag && (lock_cnt < CW'(LOCK_MAX));
    win  = last;
    if (req0 && !req1)      win = MASTER_CPU;
    else if (req1 && !req0) win = MASTER_AUX;
    else if (!hold)         win = ~last;
    any      = (req0 || req1) && !rst;
    gnt0     = any && (win == MASTER_CPU);
    gnt1     = any && (win == MASTER_AUX);
    win_lock = (win == MASTER_AUX) ? lock1 : lock0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= MASTER_AUX;
      lock_cnt  <= '0;
      lock_flag <= 1'b0;
    end else if (any) begin
      last      <= win;
      lock_flag <= win_lock;
      if ((win == last) && win_lock) begin
        if (lock_cnt < CW'(LOCK_MAX)) lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Two-master arbiter for the 16-bit mem port: grant muxing, read tagging, alignment error.
module mem_arb
  import mem_pkg::*;
#(
  parameter int unsigned AW       = ADDR_WIDTH,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wr,
  input  logic          m0_byt,
  input  logic [15:0]   m0_wr_data,
  output logic          m0_gnt,
  output logic [15:0]   m0_rd_data,
  output logic          m0_rd_valid,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wr,
  input  logic          m1_byt,
  input  logic [15:0]   m1_wr_data,
  output logic          m1_gnt,
  output logic [15:0]   m1_rd_data,
  output logic          m1_rd_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_byt,
  output logic [15:0]   mem_wr_data,
  input  logic [15:0]   mem_rd_data,
  output logic          err,
  input  logic          err_clr
);

  mem_req_t      req0, req1, sel;
  logic          any_gnt;
  logic [AW-1:0] addr_q;
  logic          tag_valid;
  master_id_t    tag_master;

  rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req0  (m0_req),
    .req1  (m1_req),
    .lock0 (m0_lock),
    .lock1 (m1_lock),
    .gnt0  (m0_gnt),
    .gnt1  (m1_gnt)
  );

  // The shared struct carries ADDR_WIDTH bits; AW is expected not to exceed it.
  always_comb begin
    req0        = '{addr: ADDR_WIDTH'(m0_addr), wr: m0_wr, byt: m0_byt, wr_data: m0_wr_data};
    req1        = '{addr: ADDR_WIDTH'(m1_addr), wr: m1_wr, byt: m1_byt, wr_data: m1_wr_data};
    any_gnt     = m0_gnt || m1_gnt;
    sel         = m1_gnt ? req1 : req0;
    mem_wr      = any_gnt && sel.wr;
    mem_byt     = any_gnt && sel.byt;
    mem_wr_data = any_gnt ? sel.wr_data : '0;
    mem_addr    = any_gnt ? AW'(sel.addr) : addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      tag_valid  <= 1'b0;
      tag_master <= MASTER_CPU;
      err        <= 1'b0;
    end else begin
      tag_valid <= any_gnt && !sel.wr;
      if (any_gnt) begin
        addr_q     <= AW'(sel.addr);
        tag_master <= m1_gnt ? MASTER_AUX : MASTER_CPU;
      end
      if (any_gnt && misaligned(sel)) err <= 1'b1;
      else if (err_clr)               err <= 1'b0;
    end
  end

  always_comb begin
    m0_rd_valid = tag_valid && (tag_master == MASTER_CPU);
    m1_rd_valid = tag_valid && (tag_master == MASTER_AUX);
    m0_rd_data  = m0_rd_valid ? mem_rd_data : '0;
    m1_rd_data  = m1_rd_valid ? mem_rd_data : '0;
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed and randomized checks of mem_arb against a grant-history reference model.
module tb_mem_arb;
  import mem_pkg::*;

  localparam int unsigned LM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_lock, m0_wr, m0_byt;
  logic [15:0] m0_addr, m0_wr_data, m0_rd_data;
  logic        m0_gnt, m0_rd_valid;
  logic        m1_req, m1_lock, m1_wr, m1_byt;
  logic [15:0] m1_addr, m1_wr_data, m1_rd_data;
  logic        m1_gnt, m1_rd_valid;
  logic [15:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_wr, mem_byt, err, err_clr;

  mem_arb #(.AW(16), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wr(m0_wr),
    .m0_byt(m0_byt), .m0_wr_data(m0_wr_data), .m0_gnt(m0_gnt),
    .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wr(m1_wr),
    .m1_byt(m1_byt), .m1_wr_data(m1_wr_data), .m1_gnt(m1_gnt),
    .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_byt(mem_byt),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM behind the port.
  logic [15:0] bram [256];
  always @(posedge clk) begin
    if (mem_wr) begin
      if (!mem_byt)         bram[mem_addr[8:1]]       <= mem_wr_data;
      else if (mem_addr[0]) bram[mem_addr[8:1]][15:8] <= mem_wr_data[7:0];
      else                  bram[mem_addr[8:1]][7:0]  <= mem_wr_data[7:0];
    end
    mem_rd_data <= bram[mem_addr[8:1]];
  end

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: grant history, held address, pending read, sticky error.
  typedef struct { bit own; bit lock; } g_t;
  g_t          hist[$];
  logic [15:0] hold;
  bit          tv, tm, merr;
  logic [15:0] td;
  int          last_pick;
  logic        s_g0, s_g1, s_v0, s_v1, s_err, s_wr, s_byt;
  logic [15:0] s_d0, s_wd;

  function automatic void model_reset();
    hist.delete();
    hist.push_back('{own: 1'b1, lock: 1'b0});
    hold = '0; tv = 0; tm = 0; td = '0; merr = 0;
  endfunction

  // Consecutive locked re-grants to the current owner, walking back through history.
  function automatic int locked_run();
    int k = 0;
    for (int i = hist.size() - 1; i >= 1; i--) begin
      if (hist[i].own == hist[i-1].own && hist[i].lock) k++;
      else break;
    end
    return k;
  endfunction

  function automatic int model_pick();
    int p;
    if (rst || (!m0_req && !m1_req)) return -1;
    if (m0_req && !m1_req) return 0;
    if (m1_req && !m0_req) return 1;
    p = hist[hist.size()-1].own ? 1 : 0;
    if (hist[hist.size()-1].lock && locked_run() < LM) return p;
    return 1 - p;
  endfunction

  task automatic step();
    int          p;
    logic [15:0] a, d;
    logic        w, b, l;
    @(negedge clk);
    if (rst) model_reset();
    p = model_pick();
    a = (p == 1) ? m1_addr    : m0_addr;
    d = (p == 1) ? m1_wr_data : m0_wr_data;
    w = (p == 1) ? m1_wr      : m0_wr;
    b = (p == 1) ? m1_byt     : m0_byt;
    l = (p == 1) ? m1_lock    : m0_lock;
    chk("m0_gnt", m0_gnt, p == 0);
    chk("m1_gnt", m1_gnt, p == 1);
    chk("mem_wr", mem_wr, (p >= 0) && w);
    chk("mem_byt", mem_byt, (p >= 0) && b);
    chk("mem_wr_data", mem_wr_data, (p >= 0) ? d : 16'h0);
    chk("mem_addr", mem_addr, (p >= 0) ? a : hold);
    chk("m0_rd_valid", m0_rd_valid, tv && !tm);
    chk("m0_rd_data", m0_rd_data, (tv && !tm) ? td : 16'h0);
    chk("m1_rd_valid", m1_rd_valid, tv && tm);
    chk("m1_rd_data", m1_rd_data, (tv && tm) ? td : 16'h0);
    chk("err", err, merr);
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_v0 = m0_rd_valid; s_v1 = m1_rd_valid;
    s_d0 = m0_rd_data; s_err = err; s_wr = mem_wr; s_byt = mem_byt; s_wd = mem_wr_data;
    last_pick = p;
    if (!rst) begin
      tv = (p >= 0) && !w;
      tm = (p == 1);
      td = bram[a[8:1]];
      if (p >= 0) begin
        hist.push_back('{own: (p == 1), lock: l});
        if (hist.size() > 24) void'(hist.pop_front());
        hold = a;
      end
      if ((p >= 0) && !b && a[0]) merr = 1;
      else if (err_clr)           merr = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_lock = 0; m0_wr = 0; m0_byt = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_lock = 0; m1_wr = 0; m1_byt = 0; m1_addr = '0; m1_wr_data = '0;
    err_clr = 0;
  endtask

  initial begin
    int  run;
    bit  seen, prev, p0, p1;
    for (int i = 0; i < 256; i++) bram[i] = 16'($urandom);
    bram[8'h80] = 16'h1234;
    idle();
    rst = 1;
    model_reset();
    step();
    m0_req = 1; m1_req = 1;
    step();
    chk("rst_gnt_forced", {s_g0, s_g1}, 2'b00);
    idle();
    rst = 0;

    // Single read from m0, data returned next cycle.
    m0_req = 1; m0_addr = 16'h0300;
    step();
    chk("t1_gnt", s_g0, 1'b1);
    idle();
    step();
    chk("t1_rd_valid", s_v0, 1'b1);
    chk("t1_rd_data", s_d0, 16'h1234);
    chk("t1_m1_valid", s_v1, 1'b0);

    // Continuous contention without lock alternates every cycle.
    m0_req = 1; m0_addr = 16'h0010; m1_req = 1; m1_addr = 16'h0020;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_busy", s_g0 | s_g1, 1'b1);
      if (i > 0) chk("t2_alt", s_g1, !prev);
      prev = s_g1;
    end

    // m1 holds lock against a waiting m0.
    idle();
    m0_req = 1; m0_addr = 16'h0030;
    step();
    m1_req = 1; m1_lock = 1; m1_addr = 16'h0040;
    run = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (s_g0) seen = 1;
      else if (s_g1) run++;
    end
    chk("t3_m0_granted", seen, 1'b1);
    chk("t3_m1_run", run, LM + 1);

    // Misaligned word write sets err; clear; clear collides with new error.
    idle();
    m1_req = 1; m1_wr = 1; m1_addr = 16'h0301; m1_wr_data = 16'hBEEF;
    step();
    chk("t4_gnt", s_g1, 1'b1);
    idle();
    step();
    chk("t4_err_set", s_err, 1'b1);
    err_clr = 1;
    step();
    err_clr = 0;
    step();
    chk("t4_err_clr", s_err, 1'b0);
    err_clr = 1; m0_req = 1; m0_addr = 16'h0101;
    step();
    idle();
    step();
    chk("t4_err_set_wins", s_err, 1'b1);

    // Reset while a read is in flight.
    idle();
    m0_req = 1; m0_addr = 16'h0040;
    step();
    rst = 1;
    step();
    chk("t5_no_rd_valid", {s_v0, s_v1}, 2'b00);
    rst = 0;
    m1_req = 1; m1_addr = 16'h0050;
    step();
    chk("t5_first_tie_m0", {s_g0, s_g1}, 2'b10);

    // Byte write by m0 alone.
    idle();
    step();
    m0_req = 1; m0_wr = 1; m0_byt = 1; m0_addr = 16'h0006; m0_wr_data = 16'h00AA;
    step();
    chk("t6_byte_write", {s_wr, s_byt, s_wd}, {1'b1, 1'b1, 16'h00AA});
    idle();
    step();
    chk("t6_one_cycle", {s_wr, s_v0, s_v1}, 3'b000);

    // Randomized traffic with requests held until granted.
    p0 = 0; p1 = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; m0_addr = 16'($urandom_range(0, 1023)); m0_wr = 1'($urandom_range(0, 1));
        m0_byt = 1'($urandom_range(0, 1)); m0_wr_data = 16'($urandom);
        m0_lock = ($urandom_range(0, 3) != 0);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; m1_addr = 16'($urandom_range(0, 1023)); m1_wr = 1'($urandom_range(0, 1));
        m1_byt = 1'($urandom_range(0, 1)); m1_wr_data = 16'($urandom);
        m1_lock = ($urandom_range(0, 3) != 0);
      end
      m0_req  = p0;
      m1_req  = p1;
      err_clr = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      step();
      if (last_pick == 0) p0 = 0;
      if (last_pick == 1) p1 = 0;
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
